// File: rtl/c3_heap_pkg.sv
// c3_heap_pkg: shared constants and types for the heap-instruction dispatcher.
// Holds the default sizing parameters, the push/pop opcode encodings, the
// dispatcher FSM state enum, the error-code encodings and a size clamp helper.
package c3_heap_pkg;

    localparam int unsigned HEAP_DEPTH_DEF = 1024;  // max heap elements
    localparam int unsigned TIMEOUT_DEF    = 15;    // WAIT-cycle limit

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_UNDER   = 2'b01;
    localparam logic [1:0] ERR_OVF_ILL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // The heap unit reports the new size; never let it exceed the capacity.
    function automatic logic [31:0] clamp_size(input logic [31:0] s, input logic [31:0] lim);
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/c3_heap_dispatch_if.sv
// c3_heap_dispatch_if: groups every non-clock/reset signal of the dispatcher.
//   cfg_*      : heap base configuration
//   cmd_*      : command handshake from the core
//   c3_*       : issue strobe/operands to the heap unit and its response
//   wb_*       : register writeback
//   err_*      : one-cycle error pulse
// Modports: slave = the dispatcher, master = the side driving commands and
// responses (core + heap unit model).
interface c3_heap_dispatch_if;
    logic        cfg_we;
    logic [31:0] cfg_base;
    logic        cmd_v;
    logic        cmd_rdy;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [31:0] cmd_data;
    logic        c3_v;
    logic [4:0]  c3_rd;
    logic [2:0]  c3_vrd1;
    logic [2:0]  c3_vrd2;
    logic [31:0] c3_data;
    logic [31:0] c3_heap_addr;
    logic [31:0] c3_heap_size;
    logic        c3_rsp_v;
    logic [4:0]  c3_rsp_rd;
    logic [31:0] c3_rsp_data;
    logic [31:0] c3_rsp_heap_size;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_v;
    logic [1:0]  err_code;

    modport slave (
        input  cfg_we, cfg_base, cmd_v, cmd_op, cmd_rd, cmd_data,
               c3_rsp_v, c3_rsp_rd, c3_rsp_data, c3_rsp_heap_size,
        output cmd_rdy, c3_v, c3_rd, c3_vrd1, c3_vrd2, c3_data, c3_heap_addr,
               c3_heap_size, wb_v, wb_rd, wb_data, err_v, err_code
    );

    modport master (
        output cfg_we, cfg_base, cmd_v, cmd_op, cmd_rd, cmd_data,
               c3_rsp_v, c3_rsp_rd, c3_rsp_data, c3_rsp_heap_size,
        input  cmd_rdy, c3_v, c3_rd, c3_vrd1, c3_vrd2, c3_data, c3_heap_addr,
               c3_heap_size, wb_v, wb_rd, wb_data, err_v, err_code
    );
endinterface

// File: rtl/c3_dispatch_timer.sv
// c3_dispatch_timer: WAIT-state watchdog for the dispatcher.
//   clk, reset : clock, async active-high reset
//   start      : count enable (high while the dispatcher waits)
//   clear      : synchronous clear (dominates start)
//   expired    : high during the TIMEOUT-th consecutive counted cycle
// Only instantiated when C3_DISPATCH_TIMEOUT_EN is defined.
module c3_dispatch_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (start)  cnt <= cnt + 1'b1;
    end

    // cnt holds the number of already-elapsed cycles, so the limit is hit one early.
    assign expired = start && !clear && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/c3_heap_dispatch.sv
// c3_heap_dispatch: accepts push/pop commands, issues them to the heap
// instruction unit, waits for the tagged response and writes the result back.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high
//   bus   : c3_heap_dispatch_if.slave (cfg, cmd, c3 issue/response, wb, err)
// Optional: define C3_DISPATCH_TIMEOUT_EN to abandon a WAIT after TIMEOUT
// cycles with error code 11; otherwise WAIT lasts until a matching response.
module c3_heap_dispatch
    import c3_heap_pkg::*;
#(
    parameter int unsigned HEAP_DEPTH = HEAP_DEPTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    c3_heap_dispatch_if.slave bus
);
    localparam logic [31:0] DEPTH = 32'(HEAP_DEPTH);

    state_t      state;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] base_q;
    logic [31:0] size_q;

    logic        in_wait, rsp_hit, rsp_miss, tmo_expired;
    logic [31:0] new_size;

    assign in_wait  = (state == ST_WAIT);
    assign rsp_hit  = in_wait && bus.c3_rsp_v && (bus.c3_rsp_rd == rd_q);
    assign rsp_miss = in_wait && bus.c3_rsp_v && (bus.c3_rsp_rd != rd_q);
    assign new_size = clamp_size(bus.c3_rsp_heap_size, DEPTH);

`ifdef C3_DISPATCH_TIMEOUT_EN
    c3_dispatch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (in_wait),
        .clear   (!in_wait),
        .expired (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_expired    = 1'b0;
`endif

    assign bus.c3_vrd2 = 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            op_q             <= '0;
            rd_q             <= '0;
            base_q           <= '0;
            size_q           <= '0;
            bus.cmd_rdy      <= 1'b0;
            bus.c3_v         <= 1'b0;
            bus.c3_rd        <= '0;
            bus.c3_vrd1      <= '0;
            bus.c3_data      <= '0;
            bus.c3_heap_addr <= '0;
            bus.c3_heap_size <= '0;
            bus.wb_v         <= 1'b0;
            bus.wb_rd        <= '0;
            bus.wb_data      <= '0;
            bus.err_v        <= 1'b0;
            bus.err_code     <= ERR_NONE;
        end else begin
            // strobes default low; each is raised for a single cycle below
            bus.c3_v     <= 1'b0;
            bus.wb_v     <= 1'b0;
            bus.err_v    <= 1'b0;
            bus.err_code <= ERR_NONE;
            case (state)
                ST_IDLE: begin
                    bus.cmd_rdy <= 1'b1;
                    if (bus.cfg_we) begin
                        // config wins over a simultaneous command
                        base_q <= bus.cfg_base;
                        size_q <= '0;
                    end else if (bus.cmd_v && bus.cmd_rdy) begin
                        op_q <= bus.cmd_op;
                        rd_q <= bus.cmd_rd;
                        if (bus.cmd_op == OP_POP && size_q == 32'd0) begin
                            bus.err_v    <= 1'b1;
                            bus.err_code <= ERR_UNDER;
                        end else if ((bus.cmd_op == OP_PUSH && size_q >= DEPTH) ||
                                     (bus.cmd_op != OP_PUSH && bus.cmd_op != OP_POP)) begin
                            bus.err_v    <= 1'b1;
                            bus.err_code <= ERR_OVF_ILL;
                        end else begin
                            bus.cmd_rdy      <= 1'b0;
                            bus.c3_v         <= 1'b1;
                            bus.c3_rd        <= bus.cmd_rd;
                            bus.c3_vrd1      <= bus.cmd_op;
                            bus.c3_data      <= bus.cmd_data;
                            bus.c3_heap_addr <= base_q;
                            bus.c3_heap_size <= size_q;
                            state            <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (rsp_hit) begin
                        size_q      <= new_size;
                        bus.wb_v    <= 1'b1;
                        bus.wb_rd   <= rd_q;
                        bus.wb_data <= (op_q == OP_POP) ? bus.c3_rsp_data : new_size;
                        state       <= ST_WB;
                    end else if (tmo_expired) begin
                        bus.err_v    <= 1'b1;
                        bus.err_code <= ERR_TIMEOUT;
                        bus.cmd_rdy  <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (rsp_miss) begin
                        bus.err_v    <= 1'b1;
                        bus.err_code <= ERR_OVF_ILL;
                    end
                end
                ST_WB: begin
                    bus.cmd_rdy <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c3_heap_dispatch.sv
// tb_c3_heap_dispatch: directed scoreboard bench for c3_heap_dispatch.
// Stimulus pushes expected issue/writeback/error records into queues; a
// negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_c3_heap_dispatch;
    import c3_heap_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] size;
    } iss_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    iss_t       iss_q[$];
    wb_t        wb_q[$];
    logic [1:0] err_q[$];

    c3_heap_dispatch_if bus();

    c3_heap_dispatch dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.c3_v) begin
                if (iss_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_issue: got rd=%0d op=%0d expected no issue", bus.c3_rd, bus.c3_vrd1);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("issue", {bus.c3_rd, bus.c3_vrd1, bus.c3_data, bus.c3_heap_addr, bus.c3_heap_size}, e);
                    check("issue_vrd2", bus.c3_vrd2, 3'b000);
                end
            end
            if (bus.wb_v) begin
                if (wb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_wb: got rd=%0d data=%0h expected no writeback", bus.wb_rd, bus.wb_data);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    check("writeback", {bus.wb_rd, bus.wb_data}, w);
                end
            end
            if (bus.err_v) begin
                if (err_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_err: got code %0d expected no error", bus.err_code);
                end else begin
                    logic [1:0] ec;
                    ec = err_q.pop_front();
                    check("err_code", bus.err_code, ec);
                end
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        while (!bus.cmd_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_rdy) begin
            tests++; fails++;
            $display("FAIL wait_rdy: got cmd_rdy=0 expected 1 within 300 cycles");
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] d);
        wait_rdy();
        bus.cmd_op   = op;
        bus.cmd_rd   = rd;
        bus.cmd_data = d;
        bus.cmd_v    = 1'b1;
        @(negedge clk);
        bus.cmd_v    = 1'b0;
    endtask

    task automatic send_rsp(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] sz);
        bus.c3_rsp_rd        = rd;
        bus.c3_rsp_data      = d;
        bus.c3_rsp_heap_size = sz;
        bus.c3_rsp_v         = 1'b1;
        @(negedge clk);
        bus.c3_rsp_v         = 1'b0;
    endtask

    task automatic do_cfg(input logic [31:0] base);
        wait_rdy();
        bus.cfg_we   = 1'b1;
        bus.cfg_base = base;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.cfg_we = 0; bus.cfg_base = 0;
        bus.cmd_v = 0; bus.cmd_op = 0; bus.cmd_rd = 0; bus.cmd_data = 0;
        bus.c3_rsp_v = 0; bus.c3_rsp_rd = 0; bus.c3_rsp_data = 0; bus.c3_rsp_heap_size = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.cmd_rdy, bus.c3_v, bus.wb_v, bus.err_v, bus.err_code, bus.c3_heap_size, bus.c3_heap_addr, bus.wb_data},
              '0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", bus.cmd_rdy, 1'b1);

        // cfg and command together: cfg applies, command dropped
        bus.cfg_we = 1'b1; bus.cfg_base = 32'h1000;
        bus.cmd_v = 1'b1; bus.cmd_op = OP_PUSH; bus.cmd_rd = 5'd9; bus.cmd_data = 32'h11;
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.cmd_v = 1'b0;
        check("cfg_blocks_cmd", {bus.c3_v, bus.cmd_rdy}, 2'b01);

        // pop on empty heap
        err_q.push_back(ERR_UNDER);
        send_cmd(OP_POP, 5'd2, 32'h0);
        check("underflow_rdy", {bus.c3_v, bus.cmd_rdy}, 2'b01);

        // push 0x2A rd=3
        iss_q.push_back('{rd: 5'd3, op: OP_PUSH, data: 32'h2A, addr: 32'h1000, size: 32'd0});
        send_cmd(OP_PUSH, 5'd3, 32'h2A);
        check("issue_latency", bus.c3_v, 1'b1);
        @(negedge clk);
        check("issue_one_cycle", bus.c3_v, 1'b0);
        wb_q.push_back('{rd: 5'd3, data: 32'd1});
        send_rsp(5'd3, 32'h0, 32'd1);
        check("wb_latency", {bus.wb_v, bus.cmd_rdy}, 2'b10);
        @(negedge clk);
        check("rdy_after_wb", {bus.wb_v, bus.cmd_rdy}, 2'b01);

        // pop rd=7 with a mismatched response first
        iss_q.push_back('{rd: 5'd7, op: OP_POP, data: 32'h0, addr: 32'h1000, size: 32'd1});
        send_cmd(OP_POP, 5'd7, 32'h0);
        @(negedge clk);
        err_q.push_back(ERR_OVF_ILL);
        send_rsp(5'd4, 32'hDEAD, 32'd9);
        check("miss_stays_wait", {bus.wb_v, bus.cmd_rdy}, 2'b00);
        wb_q.push_back('{rd: 5'd7, data: 32'h55});
        send_rsp(5'd7, 32'h55, 32'd0);
        @(negedge clk);

        // illegal opcode
        err_q.push_back(ERR_OVF_ILL);
        send_cmd(3'b101, 5'd1, 32'h0);
        check("illegal_no_issue", {bus.c3_v, bus.cmd_rdy}, 2'b01);

        // no response: timeout when enabled, indefinite wait otherwise
        iss_q.push_back('{rd: 5'd1, op: OP_PUSH, data: 32'h5, addr: 32'h1000, size: 32'd0});
        send_cmd(OP_PUSH, 5'd1, 32'h5);
`ifdef C3_DISPATCH_TIMEOUT_EN
        err_q.push_back(ERR_TIMEOUT);
        repeat (25) @(negedge clk);
        check("timeout_idle", bus.cmd_rdy, 1'b1);
        iss_q.push_back('{rd: 5'd6, op: OP_PUSH, data: 32'h77, addr: 32'h1000, size: 32'd0});
`else
        repeat (100) @(negedge clk);
        check("no_timeout_wait", {bus.cmd_rdy, bus.err_v}, 2'b00);
        wb_q.push_back('{rd: 5'd1, data: 32'd1});
        send_rsp(5'd1, 32'h0, 32'd1);
        @(negedge clk);
        iss_q.push_back('{rd: 5'd6, op: OP_PUSH, data: 32'h77, addr: 32'h1000, size: 32'd1});
`endif

        // reset in WAIT, then a stale response
        send_cmd(OP_PUSH, 5'd6, 32'h77);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_wait",
              {bus.cmd_rdy, bus.c3_v, bus.wb_v, bus.err_v, bus.c3_heap_size, bus.c3_heap_addr, bus.c3_data, bus.wb_data},
              '0);
        @(negedge clk);
        reset = 1'b0;
        send_rsp(5'd6, 32'hBAD, 32'd2);
        repeat (3) @(negedge clk);
        check("stale_rsp_ignored", {bus.wb_v, bus.cmd_rdy}, 2'b01);

        // base and size both back to 0 after reset
        iss_q.push_back('{rd: 5'd2, op: OP_PUSH, data: 32'h9, addr: 32'h0, size: 32'd0});
        send_cmd(OP_PUSH, 5'd2, 32'h9);
        @(negedge clk);
        wb_q.push_back('{rd: 5'd2, data: 32'd1});
        send_rsp(5'd2, 32'h0, 32'd1);
        @(negedge clk);

        // full heap: cfg clears size, fill to 1024, push rejected, pop still works
        do_cfg(32'h2000);
        iss_q.push_back('{rd: 5'd5, op: OP_PUSH, data: 32'h1, addr: 32'h2000, size: 32'd0});
        send_cmd(OP_PUSH, 5'd5, 32'h1);
        @(negedge clk);
        wb_q.push_back('{rd: 5'd5, data: 32'd1024});
        send_rsp(5'd5, 32'h0, 32'd1024);
        @(negedge clk);
        err_q.push_back(ERR_OVF_ILL);
        send_cmd(OP_PUSH, 5'd11, 32'h3);
        check("overflow_no_issue", {bus.c3_v, bus.cmd_rdy}, 2'b01);
        iss_q.push_back('{rd: 5'd8, op: OP_POP, data: 32'h0, addr: 32'h2000, size: 32'd1024});
        send_cmd(OP_POP, 5'd8, 32'h0);
        @(negedge clk);
        wb_q.push_back('{rd: 5'd8, data: 32'hAB});
        send_rsp(5'd8, 32'hAB, 32'd1023);

        repeat (5) @(negedge clk);
        check("iss_q_drained", iss_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/c3_heap_dispatch.md
C3_HEAP_DISPATCH -- requirements
Module: c3_heap_dispatch

Interface
REQ-001 Params SHALL be: HEAP_DEPTH 1024 (max elements); TIMEOUT 15 (WAIT-cycle limit).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 cfg_we  in  1  load heap base and clear size, honoured in IDLE only.
REQ-005 cfg_base  in  32  heap base address.
REQ-006 cmd_v / cmd_rdy  in/out  1/1  command handshake.
REQ-007 cmd_op  in  3  3'b000 push, 3'b001 pop; other values illegal.
REQ-008 cmd_rd  in  5  destination register tag.
REQ-009 cmd_data  in  32  push operand.
REQ-010 c3_v  out  1  one-cycle issue strobe to the heap instruction unit.
REQ-011 c3_rd, c3_vrd1, c3_vrd2  out  5/3/3  tag, opcode, vrd2 (constant 3'b000).
REQ-012 c3_data, c3_heap_addr, c3_heap_size  out  32 each  issue operands.
REQ-013 c3_rsp_v, c3_rsp_rd  in  1/5  response valid and tag.
REQ-014 c3_rsp_data, c3_rsp_heap_size  in  32/32  popped value, updated size.
REQ-015 wb_v, wb_rd, wb_data  out  1/5/32  one-cycle register writeback.
REQ-016 err_v, err_code  out  1/2  one-cycle error pulse; 00 none, 01 underflow, 10 overflow/illegal, 11 timeout.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, WB; cmd_rdy = 1 only in IDLE.
REQ-018 Command is accepted on cmd_v & cmd_rdy; op, rd, data latched; IDLE->ISSUE unless rejected.
REQ-019 Pop with size 0 SHALL not issue: err_v=1, code 01, stay IDLE, size unchanged.
REQ-020 Push with size == HEAP_DEPTH, or illegal op, SHALL not issue: err_v=1, code 10, stay IDLE.
REQ-021 ISSUE SHALL drive c3_v=1 for exactly one cycle with latched rd/op/data, base, current size; ->WAIT.
REQ-022 WAIT SHALL complete on c3_rsp_v with c3_rsp_rd == latched rd: size <= c3_rsp_heap_size, ->WB.
REQ-023 A response with mismatching tag SHALL be dropped with err_v=1, code 10; FSM stays in WAIT.
REQ-024 WB SHALL pulse wb_v one cycle: pop -> wb_data = c3_rsp_data; push -> wb_data = new size; ->IDLE.
REQ-025 Latency: accept at cycle N -> c3_v at N+1; response at cycle M -> wb_v at M+1; next accept no earlier than M+2.
REQ-026 cfg_we SHALL be ignored outside IDLE; cfg_we and cmd_v together in IDLE: cfg applied, command not accepted that cycle.
REQ-027 Size arithmetic SHALL be 32-bit unsigned; c3_heap_size out never exceeds HEAP_DEPTH.

Reset
REQ-028 Reset SHALL force IDLE, size 0, base 0, all outputs 0 (cmd_rdy 1 after release), at any time, including mid-WAIT; a late response after reset SHALL be dropped silently.

Configuration
REQ-029 With C3_DISPATCH_TIMEOUT_EN defined, WAIT SHALL count cycles; at TIMEOUT cycles without a matching response: err_v=1, code 11, size unchanged, ->IDLE, no wb_v.
REQ-030 Without C3_DISPATCH_TIMEOUT_EN, WAIT SHALL wait indefinitely and code 11 is never produced.

Structure
REQ-031 Package c3_heap_pkg SHALL hold opcode constants, FSM state enum, err_code constants.
REQ-032 The timeout counter SHALL be sub-module c3_dispatch_timer (start, clear, expired), instantiated only under the macro.

Verification
REQ-033 cfg base 0x1000; push 0x2A rd=3 -> c3_v next cycle with vrd1=000, data 0x2A, addr 0x1000, size 0; response size 1 -> wb_v rd=3 data 1.
REQ-034 Pop with size 0 -> no c3_v, err_v with code 01, cmd_rdy stays 1.
REQ-035 Size 1, pop rd=7, response rd=7 data 0x55 size 0 -> wb_v rd=7 data 0x55; response rd=4 first -> err code 10, still WAIT.
REQ-036 Macro on, no response for 15 cycles -> err code 11, IDLE, size unchanged; macro off -> still WAIT after 100 cycles.
REQ-037 Reset asserted in WAIT -> all outputs 0, size 0; stale response then ignored, no wb_v.
REQ-038 Size 1024, push -> err code 10, no c3_v.
